// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down-counter / countdown timer with pause, one-cycle tc pulse and sticky done.
// Optional AUTORELOAD_DOWNCNT_EN: RUN reloads from the last loaded value instead of stopping at zero.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
`ifdef AUTORELOAD_DOWNCNT_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '1;
      tc_q     <= 1'b0;
`ifdef AUTORELOAD_DOWNCNT_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
`ifdef AUTORELOAD_DOWNCNT_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tc_d     = 1'b0;
`ifdef AUTORELOAD_DOWNCNT_EN
    reload_d = reload_q;
`endif
    if (load) begin
      // A load always aborts whatever is in progress, without a tc.
      count_d = load_val;
      state_d = IDLE;
`ifdef AUTORELOAD_DOWNCNT_EN
      reload_d = load_val;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              tc_d    = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (count_q == ONE) begin
            count_d = '0;
            tc_d    = 1'b1;
`ifdef AUTORELOAD_DOWNCNT_EN
            state_d = RUN;
`else
            state_d = DONE;
`endif
          end else if (count_q == '0) begin
`ifdef AUTORELOAD_DOWNCNT_EN
            // Zero reload keeps q pinned at 0 and pulses tc every unpaused cycle.
            count_d = reload_q;
            tc_d    = (reload_q == '0);
`else
            state_d = DONE;
`endif
          end else begin
            count_d = count_q - ONE;
          end
        end
        HOLD: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    q    = count_q;
    tc   = tc_q;
    busy = (state_q == RUN) || (state_q == HOLD);
    done = (state_q == DONE);
  end

endmodule
